// File: rtl/rob_alloc_retire.sv
// Reorder buffer: allocates and retires up to 2 entries per cycle, and flushes younger entries when a mispredicted branch retires.
// Optional perf counters are built when ROB_PERF_CNT_EN is defined; otherwise both counter ports read 0.
module rob_alloc_retire #(
  parameter int ISSUE_WIDTH_MAX = 2,
  parameter int ROB_MAX_RETIRE  = 2,
  parameter int ROB_SIZE        = 16,
  parameter int ROB_SIZE_CLOG   = 4,
  parameter int SRC_LEN         = 5,
  parameter int NUM_CDB         = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ISSUE_WIDTH_MAX-1:0]          instr_val_id,
  input  logic [ISSUE_WIDTH_MAX*SRC_LEN-1:0]  rd_id,
  input  logic [ISSUE_WIDTH_MAX-1:0]          nowr_id,
  input  logic [NUM_CDB-1:0]                  cdb_val,
  input  logic [NUM_CDB*ROB_SIZE_CLOG-1:0]    cdb_robid,
  input  logic [NUM_CDB-1:0]                  cdb_mispredict,
  output logic [ROB_SIZE_CLOG-1:0]            rob_is_ptr,
  output logic [ROB_SIZE_CLOG-1:0]            rob_is_ptr_p1,
  output logic                                rob_full,
  output logic [ROB_MAX_RETIRE*SRC_LEN-1:0]   rd_ret,
  output logic [ROB_MAX_RETIRE-1:0]           val_ret,
  output logic [ROB_MAX_RETIRE-1:0]           branch_ret,
  output logic [ROB_MAX_RETIRE*ROB_SIZE_CLOG-1:0] robid_ret,
  output logic                                branch_clear_id,
  output logic [ROB_SIZE_CLOG-1:0]            mispredict_tag_id,
  output logic [31:0]                         perf_ret_cnt,
  output logic [15:0]                         perf_flush_cnt
);
  localparam int IW    = ROB_SIZE_CLOG;
  localparam int PTR_W = ROB_SIZE_CLOG + 1;
  localparam int CNT_W = ROB_SIZE_CLOG + 1;
  localparam logic [CNT_W-1:0] SIZE_C  = CNT_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(ISSUE_WIDTH_MAX);
  localparam logic [IW-1:0]    ONE_IDX = IW'(1);

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ROB_SIZE-1:0] valid_q, valid_d, done_q, done_d, misp_q, misp_d, nowr_q, nowr_d;
  logic [SRC_LEN-1:0]  rd_q [ROB_SIZE];
  logic [SRC_LEN-1:0]  rd_d [ROB_SIZE];

  logic [2*SRC_LEN-1:0] rd_ret_q, rd_ret_d;
  logic [1:0]           val_ret_q, val_ret_d, branch_ret_q, branch_ret_d;
  logic [2*IW-1:0]      robid_ret_q, robid_ret_d;
  logic                 branch_clear_q, branch_clear_d;
  logic [IW-1:0]        mispredict_tag_q, mispredict_tag_d;

  logic [IW-1:0]       h0, h1, idx0, idx1, flush_tag;
  logic                ret0, ret1, flush, alloc_en, a0, a1;
  logic [1:0]          n_alloc, n_ret;
  logic [ROB_SIZE-1:0] cdb_hit, cdb_mhit;

  assign rob_is_ptr    = tail_q[IW-1:0];
  assign rob_is_ptr_p1 = rob_is_ptr + ONE_IDX;
  assign rob_full      = (SIZE_C - count_q) < FULL_C;

  // Retire selection and allocation lane compaction from registered state.
  always_comb begin
    h0        = head_q[IW-1:0];
    h1        = h0 + ONE_IDX;
    ret0      = valid_q[h0] & done_q[h0];
    ret1      = ret0 & valid_q[h1] & done_q[h1] & ~misp_q[h0];
    flush     = (ret0 & misp_q[h0]) | (ret1 & misp_q[h1]);
    flush_tag = (ret0 & misp_q[h0]) ? h0 : h1;
    n_ret     = {1'b0, ret0} + {1'b0, ret1};
    alloc_en  = ~rob_full & ~flush;
    a0        = alloc_en & instr_val_id[0];
    a1        = alloc_en & instr_val_id[1];
    idx0      = rob_is_ptr;
    idx1      = a0 ? rob_is_ptr_p1 : rob_is_ptr;
    n_alloc   = {1'b0, a0} + {1'b0, a1};
  end

  // Per-entry CDB hits; two ports naming one entry OR their mispredict flags.
  always_comb begin
    cdb_hit  = {ROB_SIZE{1'b0}};
    cdb_mhit = {ROB_SIZE{1'b0}};
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_hit[cdb_robid[k*IW +: IW]]  = cdb_hit[cdb_robid[k*IW +: IW]] | cdb_val[k];
      cdb_mhit[cdb_robid[k*IW +: IW]] = cdb_mhit[cdb_robid[k*IW +: IW]] | (cdb_val[k] & cdb_mispredict[k]);
    end
  end

  // Next-state for pointers, count and entry array.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    misp_d  = misp_q;
    nowr_d  = nowr_q;
    rd_d    = rd_q;
    head_d  = head_q + PTR_W'(n_ret);
    tail_d  = flush ? head_d : (tail_q + PTR_W'(n_alloc));
    count_d = flush ? {CNT_W{1'b0}} : (count_q + CNT_W'(n_alloc) - CNT_W'(n_ret));
    for (int e = 0; e < ROB_SIZE; e++) begin
      if (flush) begin
        valid_d[e] = 1'b0;
      end else if (a0 && (idx0 == IW'(e))) begin
        valid_d[e] = 1'b1;
        done_d[e]  = 1'b0;
        misp_d[e]  = 1'b0;
        nowr_d[e]  = nowr_id[0];
        rd_d[e]    = rd_id[0 +: SRC_LEN];
      end else if (a1 && (idx1 == IW'(e))) begin
        valid_d[e] = 1'b1;
        done_d[e]  = 1'b0;
        misp_d[e]  = 1'b0;
        nowr_d[e]  = nowr_id[1];
        rd_d[e]    = rd_id[SRC_LEN +: SRC_LEN];
      end else begin
        // Completions to invalid entries are dropped by the valid_q mask.
        valid_d[e] = valid_q[e] & ~((ret0 && (h0 == IW'(e))) || (ret1 && (h1 == IW'(e))));
        done_d[e]  = done_q[e] | (valid_q[e] & cdb_hit[e]);
        misp_d[e]  = misp_q[e] | (valid_q[e] & cdb_mhit[e]);
      end
    end
  end

  // Retire bus contents, registered at the edge that frees the entries.
  always_comb begin
    val_ret_d        = {ret1, ret0};
    branch_ret_d     = {ret1 & nowr_q[h1], ret0 & nowr_q[h0]};
    rd_ret_d         = {ret1 ? rd_q[h1] : {SRC_LEN{1'b0}}, ret0 ? rd_q[h0] : {SRC_LEN{1'b0}}};
    robid_ret_d      = {ret1 ? h1 : {IW{1'b0}}, ret0 ? h0 : {IW{1'b0}}};
    branch_clear_d   = flush;
    mispredict_tag_d = flush ? flush_tag : mispredict_tag_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= {PTR_W{1'b0}};
      tail_q           <= {PTR_W{1'b0}};
      count_q          <= {CNT_W{1'b0}};
      valid_q          <= {ROB_SIZE{1'b0}};
      done_q           <= {ROB_SIZE{1'b0}};
      misp_q           <= {ROB_SIZE{1'b0}};
      nowr_q           <= {ROB_SIZE{1'b0}};
      for (int e = 0; e < ROB_SIZE; e++) rd_q[e] <= {SRC_LEN{1'b0}};
      val_ret_q        <= 2'b00;
      branch_ret_q     <= 2'b00;
      rd_ret_q         <= {(2*SRC_LEN){1'b0}};
      robid_ret_q      <= {(2*IW){1'b0}};
      branch_clear_q   <= 1'b0;
      mispredict_tag_q <= {IW{1'b0}};
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      misp_q           <= misp_d;
      nowr_q           <= nowr_d;
      rd_q             <= rd_d;
      val_ret_q        <= val_ret_d;
      branch_ret_q     <= branch_ret_d;
      rd_ret_q         <= rd_ret_d;
      robid_ret_q      <= robid_ret_d;
      branch_clear_q   <= branch_clear_d;
      mispredict_tag_q <= mispredict_tag_d;
    end
  end

  assign val_ret           = val_ret_q;
  assign branch_ret        = branch_ret_q;
  assign rd_ret            = rd_ret_q;
  assign robid_ret         = robid_ret_q;
  assign branch_clear_id   = branch_clear_q;
  assign mispredict_tag_id = mispredict_tag_q;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_ret_q, perf_ret_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Free-running counters of retired instructions and flushes.
  always_comb begin
    perf_ret_d   = perf_ret_q + {30'd0, n_ret};
    perf_flush_d = perf_flush_q + {15'd0, flush};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ret_q   <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_ret_q   <= perf_ret_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_ret_cnt   = perf_ret_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_ret_cnt   = 32'd0;
  assign perf_flush_cnt = 16'd0;
`endif

endmodule
